spectrum_column_writer: RTL and testbench

- Parametrised successor of the FFT bar writer: renders one spectrum bar column per Start into a frame-buffer SRAM via the burst-write handshake.
- Adds multi-channel support, per-bar peak-hold memory with frame-stamped fall decay, and per-pixel vertical gradation.
- Sits between the FFT sequencer (Start/Bar/BarIdx/Ch) and the SRAM controller (ReqBurstWrite/AddrValid).

---
 rtl/spectrum_pkg.sv | 31 +++
 rtl/peak_hold_mem.sv | 74 +++++++
 rtl/spectrum_column_writer.sv | 184 ++++++++++++++++++
 tb/tb_spectrum_column_writer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared types and helpers for the spectrum column writer and its peak-hold memory.
package spectrum_pkg;

  typedef logic [14:0] rgb555_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PEAK,
    ST_WRITE,
    ST_DONE
  } state_t;

  // Index width that stays at least 1 bit for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Scales each 5-bit component by (y+1)/2^h_w.
  function automatic rgb555_t grade(input rgb555_t c, input int unsigned y,
                                    input int unsigned h_w);
    rgb555_t r;
    int unsigned comp;
    r = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      comp = (32'(c[5*i +: 5]) * (y + 1)) >> h_w;
      r[5*i +: 5] = comp[4:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/peak_hold_mem.sv
// Per-bar peak-hold store: synchronous-read RAM of {top, stamp}, resettable valid bits,
// and the frame-stamped fall-decay that produces the new peak for the current bar.
module peak_hold_mem
  import spectrum_pkg::*;
#(
  parameter int unsigned H_W     = 7,
  parameter int unsigned STAMP_W = 8,
  parameter int unsigned DEPTH   = 128,
  localparam int unsigned A_W    = idx_w(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rd_en,
  input  logic [A_W-1:0]     addr,
  input  logic               upd_en,
  input  logic [H_W-1:0]     bar,
  input  logic [2:0]         fall_speed,
  input  logic [STAMP_W-1:0] frame_cnt,
  output logic [H_W-1:0]     top
);

  localparam int unsigned D_W = STAMP_W + 3;
  localparam logic [D_W-1:0] DROP_MAX = D_W'((1 << H_W) - 1);

  logic [H_W-1:0]     top_mem   [DEPTH];
  logic [STAMP_W-1:0] stamp_mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [A_W-1:0]     addr_q;
  logic [H_W-1:0]     rd_top;
  logic [STAMP_W-1:0] rd_stamp;
  logic               rd_valid;

  logic [STAMP_W-1:0] elapsed;
  logic [D_W-1:0]     drop_raw;
  logic [H_W-1:0]     drop;
  logic [H_W-1:0]     cur;
  logic [H_W-1:0]     decayed;

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_top   <= top_mem[addr];
      rd_stamp <= stamp_mem[addr];
    end
    if (upd_en) begin
      top_mem[addr_q]   <= top;
      stamp_mem[addr_q] <= frame_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= '0;
      rd_valid <= 1'b0;
      addr_q   <= '0;
    end else begin
      if (rd_en) begin
        rd_valid <= valid[addr];
        addr_q   <= addr;
      end
      if (upd_en) valid[addr_q] <= 1'b1;
    end
  end

  // Modulo subtraction already bounds elapsed to 2^STAMP_W-1.
  always_comb begin
    cur      = rd_valid ? rd_top : '0;
    elapsed  = frame_cnt - rd_stamp;
    drop_raw = D_W'(elapsed) * D_W'(fall_speed);
    drop     = (drop_raw > DROP_MAX) ? '1 : drop_raw[H_W-1:0];
    decayed  = (cur > drop) ? cur - drop : '0;
    top      = (bar > decayed) ? bar : decayed;
  end

endmodule

// File: rtl/spectrum_column_writer.sv
// Renders one spectrum bar column per Start into frame-buffer SRAM via burst writes,
// with multi-channel placement, peak hold with fall decay and optional gradation.
module spectrum_column_writer
  import spectrum_pkg::*;
#(
  parameter int unsigned H_W         = 7,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned NUM_BARS    = 64,
  parameter int unsigned X_W         = 9,
  parameter int unsigned CH_X_STRIDE = 128,
  parameter int unsigned STAMP_W     = 8,
  parameter int unsigned ADDR_W      = 18,
  localparam int unsigned BI_W       = idx_w(NUM_BARS),
  localparam int unsigned CH_W       = idx_w(NUM_CH)
) (
  input  logic              Clock,
  input  logic              ResetN,
  input  logic              Start,
  input  logic [H_W-1:0]    Bar,
  input  logic [BI_W-1:0]   BarIdx,
  input  logic [CH_W-1:0]   Ch,
  input  logic              NewFrame,
  input  logic              LRChange,
  input  logic              ActiveScreen,
  input  logic              DrawTop,
  input  logic              GradationEn,
  input  logic [2:0]        FallSpeed,
  input  logic [14:0]       BarColor,
  input  logic [14:0]       TopColor,
  input  logic [14:0]       BGColor,
  input  logic              AddrValid,
  output logic              ReqBurstWrite,
  output logic [ADDR_W-1:0] WrAddress,
  output logic [15:0]       WrData,
  output logic [X_W-1:0]    X,
  output logic              Busy,
  output logic              End
);

  localparam int unsigned PA_W = idx_w(NUM_CH * NUM_BARS);
  localparam logic [H_W-1:0] Y_LAST = '1;

  state_t state, state_next;
  logic               peak_phase;
  logic [STAMP_W-1:0] frame_cnt;
  logic               swap, lr_seen;
  logic [CH_W-1:0]    ch_eff, ch_q;
  logic [BI_W-1:0]    idx_q;
  logic [H_W-1:0]     bar_q, top_q, y;
  logic               draw_top_q, grad_q, screen_q;
  rgb555_t            bar_col_q, top_col_q, bg_col_q;

  logic               rd_en, upd_en, load_pix;
  logic [PA_W-1:0]    peak_addr;
  logic [H_W-1:0]     top_new;
  logic [H_W-1:0]     pix_y, pix_top;
  rgb555_t            pix_col;

  assign ch_eff    = swap ? CH_W'(NUM_CH - 1) - Ch : Ch;
  assign peak_addr = PA_W'(32'(ch_q) * NUM_BARS + 32'(idx_q));

  peak_hold_mem #(
    .H_W    (H_W),
    .STAMP_W(STAMP_W),
    .DEPTH  (NUM_CH * NUM_BARS)
  ) u_peak (
    .clk       (Clock),
    .rst_n     (ResetN),
    .rd_en     (rd_en),
    .addr      (peak_addr),
    .upd_en    (upd_en),
    .bar       (bar_q),
    .fall_speed(FallSpeed),
    .frame_cnt (frame_cnt),
    .top       (top_new)
  );

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= ST_IDLE;
    else         state <= state_next;
  end

  // Pixel words are precomputed for the next y so WrAddress/WrData come straight from flops.
  always_comb begin
    state_next    = state;
    rd_en         = 1'b0;
    upd_en        = 1'b0;
    load_pix      = 1'b0;
    pix_y         = '0;
    pix_top       = top_q;
    Busy          = 1'b0;
    End           = 1'b0;
    ReqBurstWrite = 1'b0;
    case (state)
      ST_IDLE: if (Start) state_next = ST_PEAK;
      ST_PEAK: begin
        Busy = 1'b1;
        if (!peak_phase) begin
          rd_en = 1'b1;
        end else begin
          upd_en     = 1'b1;
          load_pix   = 1'b1;
          pix_top    = top_new;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        Busy          = 1'b1;
        ReqBurstWrite = 1'b1;
        if (AddrValid) begin
          if (y == Y_LAST) begin
            state_next = ST_DONE;
          end else begin
            load_pix = 1'b1;
            pix_y    = y + H_W'(1);
          end
        end
      end
      ST_DONE: begin
        End        = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    if (draw_top_q && pix_y == pix_top && pix_top != '0) pix_col = top_col_q;
    else if (pix_y < bar_q) pix_col = grad_q ? grade(bar_col_q, 32'(pix_y), H_W) : bar_col_q;
    else pix_col = bg_col_q;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      peak_phase <= 1'b0;
      frame_cnt  <= '0;
      swap       <= 1'b0;
      lr_seen    <= 1'b0;
      ch_q       <= '0;
      idx_q      <= '0;
      bar_q      <= '0;
      top_q      <= '0;
      y          <= '0;
      draw_top_q <= 1'b0;
      grad_q     <= 1'b0;
      screen_q   <= 1'b0;
      bar_col_q  <= '0;
      top_col_q  <= '0;
      bg_col_q   <= '0;
      X          <= '0;
      WrAddress  <= '0;
      WrData     <= '0;
    end else begin
      if (NewFrame) begin
        frame_cnt <= frame_cnt + STAMP_W'(1);
        swap      <= swap ^ (lr_seen | LRChange);
        lr_seen   <= 1'b0;
      end else if (LRChange) begin
        lr_seen <= 1'b1;
      end
      if (state == ST_IDLE && Start) begin
        ch_q       <= ch_eff;
        idx_q      <= BarIdx;
        bar_q      <= Bar;
        draw_top_q <= DrawTop;
        grad_q     <= GradationEn;
        screen_q   <= ActiveScreen;
        bar_col_q  <= BarColor;
        top_col_q  <= TopColor;
        bg_col_q   <= BGColor;
        peak_phase <= 1'b0;
        X          <= X_W'(32'(ch_eff) * CH_X_STRIDE + 32'(BarIdx));
      end
      if (state == ST_PEAK) peak_phase <= ~peak_phase;
      if (upd_en) top_q <= top_new;
      if (load_pix) begin
        y         <= pix_y;
        WrAddress <= {screen_q, ~pix_y, X, 1'b0};
        WrData    <= {1'b0, pix_col};
      end
    end
  end

endmodule

// File: tb/tb_spectrum_column_writer.sv
// Directed self-checking bench for spectrum_column_writer with hand-computed expectations.
module tb_spectrum_column_writer;

  logic        Clock = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic [6:0]  Bar = '0;
  logic [5:0]  BarIdx = '0;
  logic [0:0]  Ch = '0;
  logic        NewFrame = 1'b0;
  logic        LRChange = 1'b0;
  logic        ActiveScreen = 1'b0;
  logic        DrawTop = 1'b0;
  logic        GradationEn = 1'b0;
  logic [2:0]  FallSpeed = '0;
  logic [14:0] BarColor = '0;
  logic [14:0] TopColor = '0;
  logic [14:0] BGColor = '0;
  logic        AddrValid = 1'b0;
  logic        ReqBurstWrite;
  logic [17:0] WrAddress;
  logic [15:0] WrData;
  logic [8:0]  X;
  logic        Busy;
  logic        End;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  logic [17:0] w_addr [128];
  logic [15:0] w_data [128];
  int unsigned nwords, end_cnt, stable_bad;
  logic        end_busy;

  spectrum_column_writer #(
    .H_W(7), .NUM_CH(2), .NUM_BARS(64), .X_W(9),
    .CH_X_STRIDE(128), .STAMP_W(8), .ADDR_W(18)
  ) dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Bar(Bar), .BarIdx(BarIdx),
    .Ch(Ch), .NewFrame(NewFrame), .LRChange(LRChange), .ActiveScreen(ActiveScreen),
    .DrawTop(DrawTop), .GradationEn(GradationEn), .FallSpeed(FallSpeed),
    .BarColor(BarColor), .TopColor(TopColor), .BGColor(BGColor),
    .AddrValid(AddrValid), .ReqBurstWrite(ReqBurstWrite), .WrAddress(WrAddress),
    .WrData(WrData), .X(X), .Busy(Busy), .End(End)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_frame();
    NewFrame = 1'b1;
    tick();
    NewFrame = 1'b0;
  endtask

  task automatic pulse_lr();
    LRChange = 1'b1;
    tick();
    LRChange = 1'b0;
  endtask

  task automatic do_start(input logic [6:0] bar, input logic [5:0] idx, input logic ch);
    Bar = bar;
    BarIdx = idx;
    Ch = ch;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  // Runs the burst with AddrValid at the given duty, recording accepted words.
  task automatic collect(input int unsigned duty);
    int unsigned cyc;
    int unsigned after;
    logic        prev_stall;
    logic [17:0] prev_a;
    logic [15:0] prev_d;
    cyc = 0; after = 0; prev_stall = 1'b0; prev_a = '0; prev_d = '0;
    nwords = 0; end_cnt = 0; stable_bad = 0; end_busy = 1'b0;
    while (cyc < 3000 && after < 4) begin
      AddrValid = ($urandom_range(99) < duty);
      @(negedge Clock);
      if (ReqBurstWrite === 1'b1) begin
        if (prev_stall && (WrAddress !== prev_a || WrData !== prev_d)) stable_bad++;
        if (AddrValid) begin
          if (nwords < 128) begin
            w_addr[nwords] = WrAddress;
            w_data[nwords] = WrData;
          end
          nwords++;
        end
        prev_stall = ~AddrValid;
        prev_a = WrAddress;
        prev_d = WrData;
      end else begin
        prev_stall = 1'b0;
      end
      if (End === 1'b1) begin
        end_cnt++;
        end_busy = Busy;
      end
      if (end_cnt > 0) after++;
      tick();
      cyc++;
    end
    AddrValid = 1'b0;
  endtask

  function automatic logic [15:0] model_pix(input int unsigned yy, input int unsigned top,
                                            input int unsigned bar, input logic dt,
                                            input logic gr);
    logic [14:0] c;
    if (dt && yy == top && top != 0) c = TopColor;
    else if (yy < bar) begin
      c = BarColor;
      if (gr)
        for (int k = 0; k < 3; k++)
          c[5*k +: 5] = 5'((int'(BarColor[5*k +: 5]) * int'(yy + 1)) / 128);
    end else c = BGColor;
    return {1'b0, c};
  endfunction

  task automatic finish_job(input string tag, input int unsigned xx, input int unsigned top,
                            input int unsigned bar, input logic dt, input logic gr,
                            input logic scr);
    logic [6:0]  row;
    logic [8:0]  x9;
    logic [17:0] ea;
    x9 = 9'(xx);
    check({tag, "_nwords"}, nwords, 128);
    check({tag, "_end_cnt"}, end_cnt, 1);
    check({tag, "_busy_at_end"}, 32'(end_busy), 0);
    check({tag, "_stall_stable"}, stable_bad, 0);
    check({tag, "_x"}, 32'(X), xx);
    for (int unsigned i = 0; i < 128; i++) begin
      row = 7'(127 - i);
      ea = {scr, row, x9, 1'b0};
      check($sformatf("%s_addr[%0d]", tag, i), 32'(w_addr[i]), 32'(ea));
      check($sformatf("%s_data[%0d]", tag, i), 32'(w_data[i]), 32'(model_pix(i, top, bar, dt, gr)));
    end
  endtask

  initial begin
    BarColor = 15'h001F;
    TopColor = 15'h7C00;
    BGColor  = 15'h03E0;
    tick();
    tick();
    check("rst_req", 32'(ReqBurstWrite), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_end", 32'(End), 0);
    check("rst_addr", 32'(WrAddress), 0);
    check("rst_data", 32'(WrData), 0);
    check("rst_x", 32'(X), 0);
    ResetN = 1'b1;
    tick();

    // Basic column: Bar=10, Idx=3, Ch=0, screen 1, AddrValid always high.
    ActiveScreen = 1'b1;
    DrawTop = 1'b1;
    do_start(7'd10, 6'd3, 1'b0);
    @(negedge Clock);
    check("basic_busy_after_start", 32'(Busy), 1);
    tick();
    collect(100);
    finish_job("basic", 3, 10, 10, 1'b1, 1'b0, 1'b1);
    check("basic_first_addr", 32'(w_addr[0]), 32'h3FC06);
    check("basic_last_addr", 32'(w_addr[127]), 32'h20006);
    check("basic_y9_bar", 32'(w_data[9]), 32'h001F);
    check("basic_y10_top", 32'(w_data[10]), 32'h7C00);
    check("basic_y11_bg", 32'(w_data[11]), 32'h03E0);

    // Peak decay: two bars at 100, five frames, then Bar=0 with FallSpeed 4 and 0.
    ActiveScreen = 1'b0;
    FallSpeed = 3'd4;
    do_start(7'd100, 6'd5, 1'b1);
    collect(100);
    finish_job("decay_seed5", 133, 100, 100, 1'b1, 1'b0, 1'b0);
    do_start(7'd100, 6'd6, 1'b1);
    collect(100);
    finish_job("decay_seed6", 134, 100, 100, 1'b1, 1'b0, 1'b0);
    repeat (5) pulse_frame();
    do_start(7'd0, 6'd5, 1'b1);
    collect(100);
    finish_job("decay_fs4", 133, 80, 0, 1'b1, 1'b0, 1'b0);
    check("decay_fs4_y80_top", 32'(w_data[80]), 32'h7C00);
    FallSpeed = 3'd0;
    do_start(7'd0, 6'd6, 1'b1);
    collect(100);
    finish_job("decay_fs0", 134, 100, 0, 1'b1, 1'b0, 1'b0);
    check("decay_fs0_y100_top", 32'(w_data[100]), 32'h7C00);

    // Stalled burst at 30% duty; ActiveScreen changes after Start must not matter.
    ActiveScreen = 1'b1;
    do_start(7'd20, 6'd7, 1'b0);
    ActiveScreen = 1'b0;
    collect(30);
    finish_job("stall", 7, 20, 20, 1'b1, 1'b0, 1'b1);

    // Channel swap takes effect only at NewFrame.
    pulse_lr();
    do_start(7'd5, 6'd9, 1'b0);
    collect(100);
    finish_job("noswap", 9, 5, 5, 1'b1, 1'b0, 1'b0);
    pulse_frame();
    do_start(7'd5, 6'd9, 1'b0);
    collect(100);
    finish_job("swap", 137, 5, 5, 1'b1, 1'b0, 1'b0);

    // Gradation, plus a Start issued while Busy that must be ignored.
    BarColor = 15'h7FFF;
    GradationEn = 1'b1;
    do_start(7'd100, 6'd10, 1'b0);
    BarIdx = 6'd20;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    collect(100);
    finish_job("grad", 138, 100, 100, 1'b1, 1'b1, 1'b0);
    check("grad_y63", 32'(w_data[63]), 32'h3DEF);
    check("grad_idle_after", 32'(Busy), 0);
    BarColor = 15'h001F;
    GradationEn = 1'b0;

    // Reset in the middle of a burst, then the same peak entry must read as empty.
    AddrValid = 1'b1;
    do_start(7'd50, 6'd11, 1'b0);
    repeat (6) tick();
    check("midrst_in_write", 32'(ReqBurstWrite), 1);
    #2 ResetN = 1'b0;
    #1;
    check("midrst_req", 32'(ReqBurstWrite), 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_end", 32'(End), 0);
    check("midrst_addr", 32'(WrAddress), 0);
    check("midrst_data", 32'(WrData), 0);
    tick();
    ResetN = 1'b1;
    AddrValid = 1'b0;
    tick();
    do_start(7'd0, 6'd11, 1'b1);
    collect(100);
    finish_job("post_rst", 139, 0, 0, 1'b1, 1'b0, 1'b0);
    check("post_rst_y50_bg", 32'(w_data[50]), 32'h03E0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
